scan_chain_ctrl: RTL and testbench

- Serial loader/unloader for a daisy-chain of scan flops.
- Accepts a parallel config word over a valid/ready handshake, serializes it LSB-first onto shift_i, and generates shift_en and a divided shift_clk.
- Captures the chain's shift_o stream into a parallel readback word, then optionally issues a one-cycle commit pulse to the functional flop clock domain.
- Sits directly upstream of the flop chain: its shift_* outputs drive the first flop, and the last flop's shift_o returns here.

---
 rtl/scan_chain_ctrl_pkg.sv | 18 +
 rtl/scan_chain_ctrl_if.sv | 25 ++
 rtl/scan_chain_ctrl_clk_div_phase.sv | 34 +++
 rtl/scan_chain_ctrl.sv | 162 ++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// scan_pkg: shared types and defaults for the scan chain controller.
//   state_t        - controller FSM states
//   DEF_CHAIN_LEN  - default number of flops in the chain
//   DEF_CLK_DIV    - default clk cycles per shift_clk half-period
package scan_pkg;

    localparam int DEF_CHAIN_LEN = 32;
    localparam int DEF_CLK_DIV   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOW    = 3'd1,
        HIGH   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: host-side config/readback bundle.
//   cfg_valid/cfg_ready - handshake for a config word
//   cfg_data/cfg_commit - word to shift in (bit 0 first) and commit request
//   rd_valid/rd_data    - one-cycle pulse with the previous chain contents
// master = host driving config words, slave = controller.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = scan_pkg::DEF_CHAIN_LEN
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHAIN_LEN-1:0] cfg_data;
    logic                 cfg_commit;
    logic                 rd_valid;
    logic [CHAIN_LEN-1:0] rd_data;

    modport master (
        output cfg_valid, cfg_data, cfg_commit,
        input  cfg_ready, rd_valid, rd_data
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_commit,
        output cfg_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/scan_chain_ctrl_clk_div_phase.sv
// clk_div_phase: free-running 0..CLK_DIV-1 counter used to time each
// half-period of shift_clk.
//   clk, rst - clock and synchronous active-high reset
//   clear    - force the count back to 0
//   run      - advance the count
//   last     - high while the count is CLK_DIV-1 (final cycle of a phase)
module clk_div_phase #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic last
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_reg;

    assign last = (div_reg == DIV_W'(CLK_DIV - 1));

    // Wrapping on last lets LOW hand over to HIGH (and back) with no gap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_reg <= '0;
        end else if (run) begin
            if (last) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a config word LSB-first into a daisy chain of
// scan flops while capturing the chain's previous contents.
//   clk, rst      - clock and synchronous active-high reset
//   host (slave)  - cfg handshake in, rd_valid/rd_data readback out
//   shift_clk     - divided shift clock to the chain
//   shift_en      - scan enable to the chain
//   shift_i       - serial data to the first flop
//   shift_o       - serial data from the last flop
//   commit        - one-cycle functional capture request
//   busy          - high whenever not IDLE
// All outputs come straight from flops so the chain sees glitch-free
// shift_clk/shift_en/shift_i.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter  int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter  int CLK_DIV   = DEF_CLK_DIV,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    scan_chain_ctrl_if.slave       host,
    output logic                   shift_clk,
    output logic                   shift_en,
    output logic                   shift_i,
    input  logic                   shift_o,
    output logic                   commit,
    output logic                   busy
);
    state_t               state_reg, state_next;
    logic [CHAIN_LEN-1:0] sreg_reg;
    logic [CHAIN_LEN-1:0] rd_data_reg;
    logic [CNT_W-1:0]     bit_reg;
    logic                 commit_flag_reg;

    logic shift_clk_reg, shift_en_reg, commit_reg, rd_valid_reg, busy_reg, cfg_ready_reg;
    logic shift_clk_next, shift_en_next, commit_next, rd_valid_next, busy_next, cfg_ready_next;

    logic                 div_last;
    logic                 take;
    logic                 last_bit;
    logic                 capture;
    logic [CHAIN_LEN-1:0] hit;

    assign take     = (state_reg == IDLE) && host.cfg_valid;
    assign last_bit = (bit_reg == CNT_W'(CHAIN_LEN - 1));
    // Sample shift_o on the final LOW cycle, i.e. just before shift_clk rises.
    assign capture  = (state_reg == LOW) && div_last;

    clk_div_phase #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (state_reg == IDLE),
        .run   ((state_reg == LOW) || (state_reg == HIGH)),
        .last  (div_last)
    );

    // One-hot select of the readback bit being captured this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < CHAIN_LEN; gi++) begin : g_hit
            assign hit[gi] = capture && (bit_reg == CNT_W'(gi));
        end
    endgenerate

    // State register plus inline shift/readback datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            sreg_reg        <= '0;
            rd_data_reg     <= '0;
            bit_reg         <= '0;
            commit_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                sreg_reg        <= host.cfg_data;
                commit_flag_reg <= host.cfg_commit;
                bit_reg         <= '0;
            end else if ((state_reg == HIGH) && div_last) begin
                // Zero fill leaves shift_i low once the word is fully out.
                sreg_reg <= sreg_reg >> 1;
                bit_reg  <= bit_reg + CNT_W'(1);
            end
            if (capture) begin
                rd_data_reg <= (rd_data_reg & ~hit) | (hit & {CHAIN_LEN{shift_o}});
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take) state_next = LOW;
            LOW:     if (div_last) state_next = HIGH;
            HIGH: begin
                if (div_last) begin
                    if (last_bit) begin
                        state_next = commit_flag_reg ? COMMIT : DONE;
                    end else begin
                        state_next = LOW;
                    end
                end
            end
            COMMIT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state; registered below.
    always_comb begin
        shift_clk_next = 1'b0;
        shift_en_next  = 1'b0;
        commit_next    = 1'b0;
        rd_valid_next  = 1'b0;
        busy_next      = 1'b1;
        cfg_ready_next = 1'b0;
        case (state_next)
            IDLE: begin
                busy_next      = 1'b0;
                cfg_ready_next = 1'b1;
            end
            LOW:     shift_en_next = 1'b1;
            HIGH: begin
                shift_en_next  = 1'b1;
                shift_clk_next = 1'b1;
            end
            COMMIT:  commit_next   = 1'b1;
            DONE:    rd_valid_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_clk_reg <= 1'b0;
            shift_en_reg  <= 1'b0;
            commit_reg    <= 1'b0;
            rd_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            cfg_ready_reg <= 1'b1;
        end else begin
            shift_clk_reg <= shift_clk_next;
            shift_en_reg  <= shift_en_next;
            commit_reg    <= commit_next;
            rd_valid_reg  <= rd_valid_next;
            busy_reg      <= busy_next;
            cfg_ready_reg <= cfg_ready_next;
        end
    end

    assign shift_clk      = shift_clk_reg;
    assign shift_en       = shift_en_reg;
    assign shift_i        = sreg_reg[0];
    assign commit         = commit_reg;
    assign busy           = busy_reg;
    assign host.cfg_ready = cfg_ready_reg;
    assign host.rd_valid  = rd_valid_reg;
    assign host.rd_data   = rd_data_reg;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench for scan_chain_ctrl with two instances
// (CLK_DIV=2 and CLK_DIV=1), each driving a behavioural 8-flop scan chain.
module tb_scan_chain_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    scan_chain_ctrl_if #(.CHAIN_LEN(N)) h0();
    scan_chain_ctrl_if #(.CHAIN_LEN(N)) h1();

    logic s0_clk, s0_en, s0_i, s0_o, c0, b0;
    logic s1_clk, s1_en, s1_i, s1_o, c1, b1;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .host(h0),
        .shift_clk(s0_clk), .shift_en(s0_en), .shift_i(s0_i), .shift_o(s0_o),
        .commit(c0), .busy(b0)
    );

    scan_chain_ctrl #(.CHAIN_LEN(N), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .host(h1),
        .shift_clk(s1_clk), .shift_en(s1_en), .shift_i(s1_i), .shift_o(s1_o),
        .commit(c1), .busy(b1)
    );

    // Behavioural chains: shift_i enters at the top, shift_o leaves bit 0.
    logic [N-1:0] chain0 = '0;
    logic [N-1:0] chain1 = '0;
    assign s0_o = chain0[0];
    assign s1_o = chain1[0];
    always @(posedge s0_clk) if (s0_en) chain0 <= {s0_i, chain0[N-1:1]};
    always @(posedge s1_clk) if (s1_en) chain1 <= {s1_i, chain1[N-1:1]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitors: rising-edge count, edge spacing, shift_i hold, commit count.
    int   rise0 = 0, space_bad0 = 0, last_rise0 = 0, hold_bad0 = 0, commit_cnt0 = 0;
    logic prev_clk0 = 1'b0, held_i0 = 1'b0;
    always @(negedge clk) begin
        if (!s0_en) last_rise0 = 0;
        if (s0_clk && !prev_clk0) begin
            rise0++;
            if (last_rise0 != 0 && cyc - last_rise0 != 4) space_bad0++;
            last_rise0 = cyc;
            held_i0 = s0_i;
        end else if (s0_clk && s0_i != held_i0) begin
            hold_bad0++;
        end
        prev_clk0 = s0_clk;
        if (c0) commit_cnt0++;
    end

    int   rise1 = 0, space_bad1 = 0, last_rise1 = 0, hold_bad1 = 0;
    logic prev_clk1 = 1'b0, held_i1 = 1'b0;
    always @(negedge clk) begin
        if (!s1_en) last_rise1 = 0;
        if (s1_clk && !prev_clk1) begin
            rise1++;
            if (last_rise1 != 0 && cyc - last_rise1 != 2) space_bad1++;
            last_rise1 = cyc;
            held_i1 = s1_i;
        end else if (s1_clk && s1_i != held_i1) begin
            hold_bad1++;
        end
        prev_clk1 = s1_clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    int hs_cyc = 0;

    // Offer a word to dut0 and return on the negedge of cycle 1 after the handshake.
    task automatic start0(input logic [N-1:0] d, input logic cm);
        int w;
        @(negedge clk);
        h0.cfg_valid  = 1'b1;
        h0.cfg_data   = d;
        h0.cfg_commit = cm;
        w = 0;
        while (!h0.cfg_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!h0.cfg_ready) chk("hs_timeout", 32'd0, 32'd1);
        hs_cyc = cyc;
        @(negedge clk);
        h0.cfg_valid = 1'b0;
    endtask

    // Wait for rd_valid; report its cycle index and where commit appeared.
    task automatic wait0(output int n, output int commit_at, output logic en_at);
        commit_at = 0;
        en_at     = 1'b1;
        while (!h0.rd_valid && cyc - hs_cyc < 300) begin
            @(negedge clk);
            if (c0) begin
                commit_at = cyc - hs_cyc;
                en_at     = s0_en;
            end
        end
        n = cyc - hs_cyc;
    endtask

    initial begin
        int   n, ca, r, cc, sb, hb, old_hs;
        logic en;

        rst = 1'b1;
        h0.cfg_valid = 1'b0; h0.cfg_data = '0; h0.cfg_commit = 1'b0;
        h1.cfg_valid = 1'b0; h1.cfg_data = '0; h1.cfg_commit = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cfg_ready", 32'(h0.cfg_ready), 32'd1);
        chk("rst_busy",      32'(b0),           32'd0);
        chk("rst_shift_clk", 32'(s0_clk),       32'd0);
        chk("rst_shift_en",  32'(s0_en),        32'd0);
        chk("rst_shift_i",   32'(s0_i),         32'd0);
        chk("rst_commit",    32'(c0),           32'd0);
        chk("rst_rd_valid",  32'(h0.rd_valid),  32'd0);
        chk("rst_rd_data",   32'(h0.rd_data),   32'd0);
        rst = 1'b0;

        // Load 0xA5 onto an empty chain
        r = rise0; cc = commit_cnt0; sb = space_bad0; hb = hold_bad0;
        start0(8'hA5, 1'b0);
        chk("load_busy",      32'(b0),           32'd1);
        chk("load_cfg_ready", 32'(h0.cfg_ready), 32'd0);
        wait0(n, ca, en);
        chk("load_latency",   32'(n),               32'd33);
        chk("load_rd_data",   32'(h0.rd_data),      32'h00);
        chk("load_chain",     32'(chain0),          32'hA5);
        chk("load_rises",     32'(rise0 - r),       32'd8);
        chk("load_spacing",   32'(space_bad0 - sb), 32'd0);
        chk("load_commit",    32'(commit_cnt0 - cc), 32'd0);

        // Readback of the previous word
        start0(8'h3C, 1'b0);
        wait0(n, ca, en);
        chk("rb_latency", 32'(n),              32'd33);
        chk("rb_rd_data", 32'(h0.rd_data),     32'hA5);
        chk("rb_chain",   32'(chain0),         32'h3C);
        chk("rb_hold",    32'(hold_bad0 - hb), 32'd0);

        // Commit pulse just before rd_valid, with shift_en low
        cc = commit_cnt0;
        start0(8'hFF, 1'b1);
        wait0(n, ca, en);
        chk("cm_latency",   32'(n),                 32'd34);
        chk("cm_at",        32'(ca),                32'd33);
        chk("cm_shift_en",  32'(en),                32'd0);
        chk("cm_count",     32'(commit_cnt0 - cc),  32'd1);
        chk("cm_rd_data",   32'(h0.rd_data),        32'h3C);
        chk("cm_chain",     32'(chain0),            32'hFF);

        // Word offered while busy waits for the first IDLE cycle
        start0(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        h0.cfg_valid = 1'b1; h0.cfg_data = 8'h11; h0.cfg_commit = 1'b0;
        @(negedge clk);
        chk("busy_ready", 32'(h0.cfg_ready), 32'd0);
        old_hs = hs_cyc;
        wait0(n, ca, en);
        chk("busy_first_latency", 32'(n),              32'd33);
        chk("busy_first_rd",      32'(h0.rd_data),     32'hFF);
        chk("busy_ready_done",    32'(h0.cfg_ready),   32'd0);
        start0(8'h11, 1'b0);
        chk("busy_accept_cycle",  32'(hs_cyc - old_hs), 32'd34);
        wait0(n, ca, en);
        chk("busy_rd_data", 32'(h0.rd_data), 32'h5A);
        chk("busy_chain",   32'(chain0),     32'h11);

        // Reset in the middle of bit 4
        r = rise0;
        start0(8'h66, 1'b0);
        repeat (17) @(negedge clk);
        chk("mid_rises", 32'(rise0 - r), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_shift_clk", 32'(s0_clk),       32'd0);
        chk("mid_shift_en",  32'(s0_en),        32'd0);
        chk("mid_shift_i",   32'(s0_i),         32'd0);
        chk("mid_busy",      32'(b0),           32'd0);
        chk("mid_rd_valid",  32'(h0.rd_valid),  32'd0);
        chk("mid_rd_data",   32'(h0.rd_data),   32'h00);
        chk("mid_cfg_ready", 32'(h0.cfg_ready), 32'd1);

        // CLK_DIV=1 instance
        r = rise1; sb = space_bad1; hb = hold_bad1;
        @(negedge clk);
        chk("d1_ready", 32'(h1.cfg_ready), 32'd1);
        h1.cfg_valid = 1'b1; h1.cfg_data = 8'h01; h1.cfg_commit = 1'b0;
        old_hs = cyc;
        @(negedge clk);
        h1.cfg_valid = 1'b0;
        while (!h1.rd_valid && cyc - old_hs < 300) @(negedge clk);
        chk("d1_latency", 32'(cyc - old_hs),    32'd17);
        chk("d1_rd_data", 32'(h1.rd_data),      32'h00);
        chk("d1_chain",   32'(chain1),          32'h01);
        chk("d1_rises",   32'(rise1 - r),       32'd8);
        chk("d1_spacing", 32'(space_bad1 - sb), 32'd0);
        chk("d1_hold",    32'(hold_bad1 - hb),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
